// File: rtl/sdm_pdm_enc.sv
// Sigma-delta pulse-density encoder: each signed sample becomes an L-bit frame
// with (sample + 2^BMSB) ones, spread by a first-order error-feedback accumulator.
module sdm_pdm_enc #(
    parameter int BMSB = 3,
    parameter int DIV  = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [BMSB:0] wdata_i,
    output logic          full_o,
    output logic          empty_o,
    output logic          tx_o,
    output logic          frame_o,
    output logic          busy_o,
    output logic [1:0]    cst_o
);
    localparam int W  = BMSB + 1;
    localparam int AW = BMSB + 2;
    localparam int L  = 1 << W;
    localparam int DW = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV);
    localparam logic [BMSB:0]   BIT_LAST = '1;
    localparam logic [BMSB:0]   MSB_MASK = W'(1) << BMSB;
    localparam logic [AW-1:0]   L_ACC    = AW'(L);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_ILL   = 2'b11
    } state_t;

    // Handshake: push_i is accepted when the FIFO is not full, or when it is full
    // but a pop happens in the same clk; otherwise the sample is silently dropped.
    logic [BMSB:0] mem_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    cnt_q, cnt_d;
    logic          full_q, empty_q;
    logic          pop, push_ok;
    logic [BMSB:0] head_n;

    state_t        state_q, state_d;
    logic [BMSB:0] n_q, n_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [BMSB:0] bitcnt_q, bitcnt_d;
    logic [DW-1:0] divcnt_q, divcnt_d;
    logic          tx_q, tx_d;
    logic          frame_q, frame_d;
    logic [AW:0]   nxt;

    // Offset-binary conversion: flipping the sign bit adds 2^BMSB.
    assign head_n  = mem_q[rd_ptr_q] ^ MSB_MASK;
    assign push_ok = push_i && (!full_q || pop);

    // Returns {bit, next accumulator} for one error-feedback step.
    function automatic logic [AW:0] step(input logic [AW-1:0] acc, input logic [BMSB:0] n);
        logic [AW-1:0] s;
        s = acc + AW'(n);
        if (s >= L_ACC) step = {1'b1, s - L_ACC};
        else            step = {1'b0, s};
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)              cnt_d = 2'd0;
        else if (push_ok && !pop) cnt_d = cnt_q + 2'd1;
        else if (!push_ok && pop) cnt_d = cnt_q - 2'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else if (clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop)     rd_ptr_q <= ~rd_ptr_q;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == 2'd2);
            empty_q <= (cnt_d == 2'd0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        acc_d    = acc_q;
        bitcnt_d = bitcnt_q;
        divcnt_d = divcnt_q;
        tx_d     = tx_q;
        frame_d  = 1'b0;
        pop      = 1'b0;
        nxt      = '0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b0;
                if (!empty_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!empty_q) begin
                    pop      = 1'b1;
                    n_d      = head_n;
                    nxt      = step('0, head_n);
                    tx_d     = nxt[AW];
                    acc_d    = nxt[AW-1:0];
                    bitcnt_d = '0;
                    divcnt_d = '0;
                    frame_d  = 1'b1;
                    state_d  = ST_SHIFT;
                end else begin
                    tx_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (divcnt_q != DIV_LAST) begin
                    divcnt_d = divcnt_q + 1'b1;
                end else begin
                    divcnt_d = '0;
                    if (bitcnt_q != BIT_LAST) begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        nxt      = step(acc_q, n_q);
                        tx_d     = nxt[AW];
                        acc_d    = nxt[AW-1:0];
                    end else if (!empty_q) begin
                        // Frame end with data waiting: reload so bit 0 follows with no gap.
                        pop      = 1'b1;
                        n_d      = head_n;
                        nxt      = step('0, head_n);
                        tx_d     = nxt[AW];
                        acc_d    = nxt[AW-1:0];
                        bitcnt_d = '0;
                        frame_d  = 1'b1;
                    end else begin
                        tx_d    = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        if (clear_i) begin
            state_d = ST_IDLE;
            tx_d    = 1'b0;
            frame_d = 1'b0;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            acc_q    <= '0;
            bitcnt_q <= '0;
            divcnt_q <= '0;
            tx_q     <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            acc_q    <= acc_d;
            bitcnt_q <= bitcnt_d;
            divcnt_q <= divcnt_d;
            tx_q     <= tx_d;
            frame_q  <= frame_d;
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign tx_o    = tx_q;
    assign frame_o = frame_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign cst_o   = state_q;
endmodule

// File: tb/tb_sdm_pdm_enc.sv
// Bench for sdm_pdm_enc: frames are captured bit by bit and compared against an
// arithmetic pulse-density model driven by randomized samples.
module tb_sdm_pdm_enc;
    localparam int BMSB = 3;
    localparam int DIV  = 3;
    localparam int L    = 16;
    localparam int BP   = DIV + 1;

    logic       clk = 1'b0;
    logic       rst, clear, push;
    logic [3:0] wdata;
    logic       full_o, empty_o, tx_o, frame_o, busy_o;
    logic [1:0] cst_o;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    sdm_pdm_enc #(.BMSB(BMSB), .DIV(DIV)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .push_i(push), .wdata_i(wdata),
        .full_o(full_o), .empty_o(empty_o), .tx_o(tx_o), .frame_o(frame_o),
        .busy_o(busy_o), .cst_o(cst_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input int code);
        push  = 1'b1;
        wdata = 4'(code);
        tick();
        push  = 1'b0;
    endtask

    // Bit k is one exactly when floor((k+1)n/L) exceeds floor(kn/L).
    function automatic logic [L-1:0] ref_frame(input logic [3:0] code);
        int n;
        logic [L-1:0] r;
        n = int'($signed(code)) + 8;
        for (int k = 0; k < L; k++) r[k] = (((k + 1) * n) / L) > ((k * n) / L);
        return r;
    endfunction

    task automatic capture_frame(output logic [L-1:0] bits, output int waits,
                                 output int holds, output int strobes, output bit seen);
        bits = '0; waits = 0; holds = 0; strobes = 0;
        while (frame_o !== 1'b1 && waits < 400) begin
            tick();
            waits++;
        end
        seen = (frame_o === 1'b1);
        if (!seen) return;
        for (int j = 0; j < L * BP; j++) begin
            if (j % BP == 0) bits[j / BP] = tx_o;
            else if (tx_o !== bits[j / BP]) holds++;
            if (frame_o === 1'b1) strobes++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; push = 1'b0; wdata = '0;
        tick(); tick();
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full_o); end
        checks++; if ({tx_o, frame_o, busy_o} !== 3'b000) begin errors++; $display("FAIL reset_outs: got %b want 000", {tx_o, frame_o, busy_o}); end
        checks++; if (cst_o !== 2'b00) begin errors++; $display("FAIL reset_cst: got %b want 00", cst_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_frame();
        logic [L-1:0] b; int w, h, s; bit seen;
        push_sample(0);
        checks++; if (cst_o !== 2'b00 || empty_o !== 1'b0) begin errors++; $display("FAIL t1_write: got cst=%b empty=%b want 00/0", cst_o, empty_o); end
        tick();
        checks++; if (cst_o !== 2'b01 || busy_o !== 1'b1) begin errors++; $display("FAIL t1_load: got cst=%b busy=%b want 01/1", cst_o, busy_o); end
        capture_frame(b, w, h, s, seen);
        checks++; if (!seen || w != 1) begin errors++; $display("FAIL t1_latency: got seen=%0d waits=%0d want 1/1", seen, w); end
        checks++; if (b !== 16'hAAAA) begin errors++; $display("FAIL t1_bits: got %h want aaaa", b); end
        checks++; if (h != 0 || s != 1) begin errors++; $display("FAIL t1_timing: got holds=%0d strobes=%0d want 0/1", h, s); end
        checks++; if (busy_o !== 1'b0 || tx_o !== 1'b0 || cst_o !== 2'b00) begin errors++; $display("FAIL t1_idle: got busy=%b tx=%b cst=%b want 0/0/00", busy_o, tx_o, cst_o); end
    endtask

    task automatic test_all_codes();
        int codes[16];
        for (int i = 0; i < 16; i++) codes[i] = i - 8;
        for (int i = 15; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = codes[i]; codes[i] = codes[j]; codes[j] = t;
        end
        exp_q.delete();
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    int guard;
                    guard = 0;
                    while (full_o === 1'b1 && guard < 500) begin tick(); guard++; end
                    exp_q.push_back(4'(codes[i]));
                    push_sample(codes[i]);
                end
            end
            begin
                for (int f = 0; f < 16; f++) begin
                    logic [L-1:0] b; int w, h, s; bit seen; logic [3:0] c;
                    capture_frame(b, w, h, s, seen);
                    c = (exp_q.size() > 0) ? exp_q.pop_front() : 4'h0;
                    checks++; if (!seen || b !== ref_frame(c)) begin errors++; $display("FAIL t2_bits[%0d]: got %h want %h", f, b, ref_frame(c)); end
                    checks++; if ($countones(b) != int'($signed(c)) + 8) begin errors++; $display("FAIL t2_pop[%0d]: got %0d want %0d", f, $countones(b), int'($signed(c)) + 8); end
                    checks++; if (h != 0 || s != 1) begin errors++; $display("FAIL t2_timing[%0d]: got holds=%0d strobes=%0d want 0/1", f, h, s); end
                    if (f > 0) begin
                        checks++; if (w != 0) begin errors++; $display("FAIL t2_gap[%0d]: got %0d want 0", f, w); end
                    end
                end
            end
        join
        checks++; if (busy_o !== 1'b0 || tx_o !== 1'b0) begin errors++; $display("FAIL t2_idle: got busy=%b tx=%b want 0/0", busy_o, tx_o); end
    endtask

    task automatic test_fifo_full();
        logic [L-1:0] b; int w, h, s, act; bit seen; logic [3:0] c1, c2, c3;
        c1 = 4'($urandom_range(15, 0)); c2 = 4'($urandom_range(15, 0)); c3 = 4'($urandom_range(15, 0));
        push_sample(int'($signed(4'($urandom_range(15, 0)))));
        repeat (10) tick();
        push_sample(int'($signed(c1)));
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL t3_full1: got %b want 0", full_o); end
        push_sample(int'($signed(c2)));
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL t3_full2: got %b want 1", full_o); end
        push_sample(int'($signed(c3)));
        checks++; if (full_o !== 1'b1 || empty_o !== 1'b0) begin errors++; $display("FAIL t3_drop: got full=%b empty=%b want 1/0", full_o, empty_o); end
        capture_frame(b, w, h, s, seen);
        checks++; if (!seen || b !== ref_frame(c1)) begin errors++; $display("FAIL t3_first: got %h want %h", b, ref_frame(c1)); end
        capture_frame(b, w, h, s, seen);
        checks++; if (!seen || w != 0 || b !== ref_frame(c2)) begin errors++; $display("FAIL t3_second: got %h waits=%0d want %h/0", b, w, ref_frame(c2)); end
        act = 0;
        repeat (100) begin if (frame_o === 1'b1 || busy_o === 1'b1) act++; tick(); end
        checks++; if (act != 0) begin errors++; $display("FAIL t3_no_third: got %0d active clks want 0", act); end
    endtask

    task automatic test_extremes();
        logic [L-1:0] b; int w, h, s; bit seen;
        push_sample(-8);
        push_sample(7);
        capture_frame(b, w, h, s, seen);
        checks++; if (!seen || b !== 16'h0000) begin errors++; $display("FAIL t4_min: got %h want 0000", b); end
        capture_frame(b, w, h, s, seen);
        checks++; if (!seen || w != 0 || b !== 16'hFFFE) begin errors++; $display("FAIL t4_max: got %h waits=%0d want fffe/0", b, w); end
        checks++; if (busy_o !== 1'b0 || tx_o !== 1'b0 || cst_o !== 2'b00) begin errors++; $display("FAIL t4_idle: got busy=%b tx=%b cst=%b want 0/0/00", busy_o, tx_o, cst_o); end
    endtask

    task automatic test_clear();
        int w, act;
        push_sample($urandom_range(7, 0));
        push_sample($urandom_range(7, 0));
        w = 0;
        while (frame_o !== 1'b1 && w < 50) begin tick(); w++; end
        repeat (5 * BP) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (cst_o !== 2'b00 || busy_o !== 1'b0) begin errors++; $display("FAIL t5_idle: got cst=%b busy=%b want 00/0", cst_o, busy_o); end
        checks++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin errors++; $display("FAIL t5_fifo: got empty=%b full=%b want 1/0", empty_o, full_o); end
        checks++; if (tx_o !== 1'b0 || frame_o !== 1'b0) begin errors++; $display("FAIL t5_tx: got tx=%b frame=%b want 0/0", tx_o, frame_o); end
        act = 0;
        repeat (150) begin if (frame_o === 1'b1 || tx_o === 1'b1 || busy_o === 1'b1) act++; tick(); end
        checks++; if (act != 0) begin errors++; $display("FAIL t5_quiet: got %0d active clks want 0", act); end
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        logic [L-1:0] b; int w, h, s, act; bit seen; logic [3:0] c;
        push_sample(7);
        w = 0;
        while (frame_o !== 1'b1 && w < 50) begin tick(); w++; end
        push_sample(7);
        push_sample(7);
        repeat (2 * BP - 2) tick();
        checks++; if (tx_o !== 1'b1 || full_o !== 1'b1) begin errors++; $display("FAIL t6_pre: got tx=%b full=%b want 1/1", tx_o, full_o); end
        #3 rst = 1'b1;
        #1;
        checks++; if ({tx_o, frame_o, busy_o, full_o} !== 4'b0000 || cst_o !== 2'b00) begin errors++; $display("FAIL t6_async: got tx/frame/busy/full=%b cst=%b want 0000/00", {tx_o, frame_o, busy_o, full_o}, cst_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL t6_empty: got %b want 1", empty_o); end
        tick(); tick();
        rst = 1'b0;
        act = 0;
        repeat (100) begin if (frame_o === 1'b1 || tx_o === 1'b1 || busy_o === 1'b1) act++; tick(); end
        checks++; if (act != 0) begin errors++; $display("FAIL t6_quiet: got %0d active clks want 0", act); end
        c = 4'($urandom_range(15, 0));
        push_sample(int'($signed(c)));
        capture_frame(b, w, h, s, seen);
        checks++; if (!seen || w != 2 || b !== ref_frame(c)) begin errors++; $display("FAIL t6_restart: got %h waits=%0d want %h/2", b, w, ref_frame(c)); end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_all_codes();
        test_fifo_full();
        test_extremes();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
